// File: rtl/mult_pkg.sv
// Shared encodings and sizing for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ITER  = 16;
  localparam int CNT_W = 5;

endpackage

// File: rtl/fulladder16.sv
// 16-bit ripple-carry adder; the multiplier's single partial-product adder.
module fulladder16 (
  output logic [15:0] sum,
  output logic        c_out,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in
);

  logic [16:0] carry;

  // NOTE: combinational logic uses blocking '=' so each bit sees the carry computed just above it.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < 16; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[16];
  end

endmodule

// File: rtl/multiplier16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier with start/busy/done handshake.
module multiplier16_seq
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  state_t             state, state_next;
  logic [15:0]        mcand;
  logic [15:0]        acc;
  logic [15:0]        mq;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        addend;
  logic [15:0]        sum;
  logic               c_out;
  logic               load;

  assign addend = mq[0] ? mcand : 16'd0;

  fulladder16 u_adder (
    .sum   (sum),
    .c_out (c_out),
    .a     (acc),
    .b     (addend),
    .c_in  (1'b0)
  );

  // New operands are accepted only from IDLE or DONE; start in RUN is ignored.
  assign load = start && ((state == ST_IDLE) || (state == ST_DONE));

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (cnt == CNT_W'(ITER - 1)) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values;
  // the reset is synchronous and clears the datapath too, so product reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        mcand <= a;
        mq    <= b;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == ST_RUN) begin
        // Shift the 33-bit {carry, sum, mq} right by one so the carry lands in acc[15].
        {acc, mq} <= {c_out, sum, mq[15:1]};
        cnt       <= cnt + CNT_W'(1);
      end
    end
  end

  assign busy    = (state == ST_RUN);
  assign done    = (state == ST_DONE);
  assign product = {acc, mq};

endmodule

// File: tb/tb_multiplier16_seq.sv
// Scoreboard bench for multiplier16_seq: expected products queued at issue, checked at done.
module tb_multiplier16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb[$];

  multiplier16_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [15:0] op_a, input logic [15:0] op_b);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    sb.push_back(32'(op_a) * 32'(op_b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles, output int busy_cycles,
                           output logic seen);
    cycles      = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    while (!seen && cycles < limit) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cycles++;
        @(negedge clk);
        cycles++;
      end
    end
  endtask

  function automatic logic [31:0] pop_expected();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
    end
    a = 16'd5; b = 16'd6; start = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || product !== 32'd0) begin
      fails++;
      $display("FAIL reset_beats_start: busy=%b product=%h, want 0 0", busy, product);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, bc;
    logic seen;
    logic [31:0] exp;
    issue(16'd3, 16'd4);
    wait_done(40, cyc, bc, seen);
    tests++;
    if (!seen || cyc !== 16) begin
      fails++;
      $display("FAIL basic_latency: seen=%b cycles=%0d, want done after 16", seen, cyc);
    end
    tests++;
    if (bc !== 16) begin
      fails++;
      $display("FAIL basic_busy_cycles: got %0d, want 16", bc);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy_in_done: busy=%b, want 0", busy);
    end
    exp = pop_expected();
    tests++;
    if (product !== exp) begin
      fails++;
      $display("FAIL basic_product: got %0d, want %0d", product, exp);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle: done=%b busy=%b, want 0 0", done, busy);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (product !== 32'd12) begin
      fails++;
      $display("FAIL basic_hold: got %0d, want 12", product);
    end
  endtask

  task automatic test_max();
    int cyc, bc;
    logic seen;
    logic [31:0] exp;
    issue(16'hFFFF, 16'hFFFF);
    wait_done(40, cyc, bc, seen);
    exp = pop_expected();
    tests++;
    if (!seen || product !== exp || exp !== 32'hFFFE0001) begin
      fails++;
      $display("FAIL max_product: seen=%b got %h, want %h", seen, product, 32'hFFFE0001);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int cyc, bc;
    logic seen;
    logic [31:0] exp;
    logic [15:0] za[2];
    logic [15:0] zb[2];
    za[0] = 16'd0;    zb[0] = 16'd1057;
    za[1] = 16'd7677; zb[1] = 16'd0;
    for (int i = 0; i < 2; i++) begin
      issue(za[i], zb[i]);
      wait_done(40, cyc, bc, seen);
      exp = pop_expected();
      tests++;
      if (!seen || cyc !== 16 || product !== exp) begin
        fails++;
        $display("FAIL zero_%0d: seen=%b cycles=%0d product=%0d, want 16 cycles product %0d",
                 i, seen, cyc, product, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bc;
    logic seen;
    logic [31:0] exp;
    issue(16'd100, 16'd575);
    repeat (3) @(negedge clk);
    a = 16'd1; b = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, cyc, bc, seen);
    exp = pop_expected();
    tests++;
    if (!seen || cyc + 4 !== 16) begin
      fails++;
      $display("FAIL ignore_latency: seen=%b cycles=%0d, want 16", seen, cyc + 4);
    end
    tests++;
    if (product !== exp) begin
      fails++;
      $display("FAIL ignore_product: got %0d, want %0d", product, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int cyc, bc;
    logic seen;
    logic [31:0] exp;
    issue(16'd1056, 16'd1456);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
      fails++;
      $display("FAIL midrun_reset: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
    end
    wait_done(24, cyc, bc, seen);
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL midrun_no_done: done seen after %0d cycles, want none", cyc);
    end
    issue(16'd422, 16'd5673);
    wait_done(40, cyc, bc, seen);
    exp = pop_expected();
    tests++;
    if (!seen || product !== exp) begin
      fails++;
      $display("FAIL after_reset_product: seen=%b got %0d, want %0d", seen, product, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    logic seen;
    logic [31:0] exp;
    a = 16'd243; b = 16'd574; start = 1'b1;
    sb.push_back(32'(a) * 32'(b));
    @(negedge clk);
    wait_done(40, cyc, bc, seen);
    exp = pop_expected();
    tests++;
    if (!seen || product !== exp) begin
      fails++;
      $display("FAIL b2b_first: seen=%b got %0d, want %0d", seen, product, exp);
    end
    a = 16'd1057; b = 16'd7677;
    sb.push_back(32'(a) * 32'(b));
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_restart: busy=%b, want 1", busy);
    end
    wait_done(40, cyc, bc, seen);
    exp = pop_expected();
    tests++;
    if (!seen || cyc + 1 !== 17) begin
      fails++;
      $display("FAIL b2b_spacing: seen=%b spacing=%0d, want 17", seen, cyc + 1);
    end
    tests++;
    if (product !== exp) begin
      fails++;
      $display("FAIL b2b_second: got %0d, want %0d", product, exp);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
